// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encoding and funct3 size codes.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDataRead,
    StDataWrite
  } arb_state_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [2:0] FmtWord = F3Word;

endpackage

// File: rtl/unified_mem_arbiter_fetch_buffer.sv
// Instruction word buffer tagged with its fetch address; valid only while the tag matches the PC.
module unified_mem_arbiter_fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic [ADDR_WIDTH-1:0] fill_tag,
  input  logic                  retire,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_available
);

  logic [DATA_WIDTH-1:0] inst_buf_q;
  logic [ADDR_WIDTH-1:0] inst_tag_q;
  logic                  inst_valid_q;

  // A completing fill carries the newest word, so it takes precedence over a retire clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_buf_q   <= '0;
      inst_tag_q   <= '0;
      inst_valid_q <= 1'b0;
    end else if (fill) begin
      inst_buf_q   <= fill_data;
      inst_tag_q   <= fill_tag;
      inst_valid_q <= 1'b1;
    end else if (retire) begin
      inst_valid_q <= 1'b0;
    end
  end

  assign inst_data      = inst_buf_q;
  assign inst_available = inst_valid_q && (inst_tag_q == inst_address);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between instruction fetch and a single load or store per instruction.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [2:0]  FETCH_FORMAT = FmtWord
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  input  logic                  inst_read_enable,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_available,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic                  data_read_enable,
  input  logic                  data_write_enable,
  input  logic [2:0]            data_format,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  output logic [DATA_WIDTH-1:0] data_read_data,
  output logic                  data_available,
  output logic                  request_successful,
  input  logic                  retire,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [2:0]            mem_format,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ack
);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            fmt_q, fmt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wr_done_q, wr_done_d;
  logic                  fetch_fill;

  assign fetch_fill = (state_q == StFetch) && mem_ack;

  unified_mem_arbiter_fetch_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fetch_buffer (
    .clock         (clock),
    .reset         (reset),
    .fill          (fetch_fill),
    .fill_data     (mem_read_data),
    .fill_tag      (addr_q),
    .retire        (retire),
    .inst_address  (inst_address),
    .inst_data     (inst_data),
    .inst_available(inst_available)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fmt_d        = fmt_q;
    wdata_d      = wdata_q;
    re_d         = re_q;
    we_d         = we_q;
    data_buf_d   = data_buf_q;
    data_valid_d = data_valid_q;
    wr_done_d    = wr_done_q;
    case (state_q)
      StIdle: begin
        // On a retire edge the PC is moving, so nothing is issued until the next cycle.
        if (!retire) begin
          if (inst_read_enable && !inst_available) begin
            state_d = StFetch;
            addr_d  = inst_address;
            fmt_d   = FETCH_FORMAT;
            re_d    = 1'b1;
          end else if (inst_available && data_read_enable && !data_valid_q) begin
            state_d = StDataRead;
            addr_d  = data_address;
            fmt_d   = data_format;
            re_d    = 1'b1;
          end else if (inst_available && data_write_enable && !wr_done_q) begin
            state_d = StDataWrite;
            addr_d  = data_address;
            fmt_d   = data_format;
            wdata_d = data_write_data;
            we_d    = 1'b1;
          end
        end
      end
      StFetch: begin
        if (mem_ack) begin
          re_d    = 1'b0;
          state_d = StIdle;
        end
      end
      StDataRead: begin
        if (mem_ack) begin
          re_d         = 1'b0;
          data_buf_d   = mem_read_data;
          data_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StDataWrite: begin
        if (mem_ack) begin
          we_d      = 1'b0;
          wr_done_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (retire) begin
      data_valid_d = 1'b0;
      wr_done_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      fmt_q        <= '0;
      wdata_q      <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      data_buf_q   <= '0;
      data_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fmt_q        <= fmt_d;
      wdata_q      <= wdata_d;
      re_q         <= re_d;
      we_q         <= we_d;
      data_buf_q   <= data_buf_d;
      data_valid_q <= data_valid_d;
      wr_done_q    <= wr_done_d;
    end
  end

  assign mem_address        = addr_q;
  assign mem_format         = fmt_q;
  assign mem_write_data     = wdata_q;
  assign mem_read_enable    = re_q;
  assign mem_write_enable   = we_q;
  assign data_read_data     = data_buf_q;
  assign data_available     = data_valid_q;
  assign request_successful = wr_done_q;

endmodule
